mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and downstream memory handshakes of mem_port_arbiter in one bundle.
// The arbiter uses the slave view; the core and bus bridge side uses the master view.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_wr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata, m_rdata, m_ready,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_wr, m_wstrb, m_addr, m_wdata,
               stall_if, stall_mem, bus_err
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata, m_rdata, m_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_wr, m_wstrb, m_addr, m_wdata,
               stall_if, stall_mem, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D) requesters, one transaction at a time.
// Define MEM_ARB_TIMEOUT_EN to abort a transaction after TIMEOUT_CYC cycles without m_ready.
//
// state  | meaning
// IDLE   | nothing outstanding; picks the next requester
// BUSY_I | fetch presented downstream, waiting for m_ready
// BUSY_D | data access presented downstream, waiting for m_ready
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} stateT;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadStarve
            $error("STARVE_LIMIT must be in 1..15");
        end
        if (TIMEOUT_CYC < 1) begin : gBadTimeout
            $error("TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    stateT       state, stateNext;
    logic [3:0]  starveCnt;
    logic        starveHit, grantI, grantD, busy, finish, timeout, busErr;
    logic        mReq, mWr;
    logic [3:0]  mWstrb;
    logic [31:0] mAddr, mWdata;
    logic        iAck, dAck;
    logic [31:0] iRdata, dRdata;

    assign busy      = (state != IDLE);
    assign starveHit = bus.i_req && (starveCnt == STARVE_MAX);
    assign grantD    = (state == IDLE) && bus.d_req && !starveHit;
    assign grantI    = (state == IDLE) && bus.i_req && !grantD;
    assign finish    = busy && (bus.m_ready || timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (grantD)      stateNext = BUSY_D;
                else if (grantI) stateNext = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (finish) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // A timed-out transaction completes with zero data instead of whatever m_rdata holds.
    always_comb begin
        iAck   = 1'b0;
        dAck   = 1'b0;
        iRdata = '0;
        dRdata = '0;
        if (finish) begin
            if (state == BUSY_I) begin
                iAck   = 1'b1;
                iRdata = bus.m_ready ? bus.m_rdata : '0;
            end
            if (state == BUSY_D) begin
                dAck   = 1'b1;
                dRdata = bus.m_ready ? bus.m_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mReq   <= 1'b0;
            mWr    <= 1'b0;
            mWstrb <= '0;
            mAddr  <= '0;
            mWdata <= '0;
        end else if (grantD) begin
            mReq   <= 1'b1;
            mWr    <= bus.d_wr;
            mWstrb <= bus.d_wstrb;
            mAddr  <= bus.d_addr;
            mWdata <= bus.d_wdata;
        end else if (grantI) begin
            mReq   <= 1'b1;
            mWr    <= 1'b0;
            mWstrb <= '0;
            mAddr  <= bus.i_addr;
            mWdata <= '0;
        end else if (finish) begin
            mReq <= 1'b0;
        end
    end

    // Counts data grants taken while fetch was also waiting; reaching the limit hands the next slot to fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (grantI) begin
            starveCnt <= '0;
        end else if (grantD) begin
            if (!bus.i_req)                    starveCnt <= '0;
            else if (starveCnt != STARVE_MAX)  starveCnt <= starveCnt + 4'd1;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYC);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [WAIT_W-1:0] waitLeft;

    assign timeout = busy && !bus.m_ready && (waitLeft == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitLeft <= WAIT_LOAD;
            busErr   <= 1'b0;
        end else begin
            if (grantD || grantI)
                waitLeft <= WAIT_LOAD;
            else if (busy && !bus.m_ready && (waitLeft != '0))
                waitLeft <= waitLeft - WAIT_ONE;
            if (timeout)
                busErr <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign busErr  = 1'b0;
`endif

    assign bus.m_req     = mReq;
    assign bus.m_wr      = mWr;
    assign bus.m_wstrb   = mWstrb;
    assign bus.m_addr    = mAddr;
    assign bus.m_wdata   = mWdata;
    assign bus.i_ack     = iAck;
    assign bus.d_ack     = dAck;
    assign bus.i_rdata   = iRdata;
    assign bus.d_rdata   = dRdata;
    assign bus.stall_if  = bus.i_req && !iAck;
    assign bus.stall_mem = bus.d_req && !dAck;
    assign bus.bus_err   = busErr;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a random run
// checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;
    localparam int TO    = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_port_arbiter_if busIf();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(busIf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        busIf.i_req = 1'b0; busIf.i_addr = '0;
        busIf.d_req = 1'b0; busIf.d_wr = 1'b0; busIf.d_wstrb = '0;
        busIf.d_addr = '0;  busIf.d_wdata = '0;
        busIf.m_ready = 1'b0; busIf.m_rdata = '0;
    endtask

    task automatic resetPulse();
        nextCycle();
        rst = 1'b1;
        idleInputs();
        nextCycle();
        rst = 1'b0;
    endtask

    // Reference model: who owns the port, the current data streak against a waiting fetch,
    // and the fields the owner asked for.
    int          mOwner = 0;
    int          mStreak = 0;
    int          mBusy = 0;
    logic        mBusErr = 1'b0;
    logic [31:0] cAddr = '0, cWdata = '0;
    logic        cWr = 1'b0;
    logic [3:0]  cWstrb = '0;

    always @(posedge clk) begin
        if (rst) begin
            mOwner = 0; mStreak = 0; mBusy = 0; mBusErr = 1'b0;
        end else if (mOwner != 0) begin
            if (busIf.m_ready) mOwner = 0;
            else if (TO_EN && mBusy == TO) begin mOwner = 0; mBusErr = 1'b1; end
            else mBusy++;
        end else if (busIf.d_req && !(busIf.i_req && mStreak == LIMIT)) begin
            mOwner = 2; mBusy = 0;
            mStreak = busIf.i_req ? ((mStreak < LIMIT) ? mStreak + 1 : LIMIT) : 0;
            cAddr = busIf.d_addr; cWr = busIf.d_wr; cWstrb = busIf.d_wstrb; cWdata = busIf.d_wdata;
        end else if (busIf.i_req) begin
            mOwner = 1; mBusy = 0; mStreak = 0;
            cAddr = busIf.i_addr; cWr = 1'b0; cWstrb = '0;
        end
    end

    always @(negedge clk) begin
        logic tmo, eI, eD;
        if (rst) begin
            check("rst m_req/m_wr/m_wstrb", {busIf.m_req, busIf.m_wr, busIf.m_wstrb}, '0);
            check("rst m_addr", busIf.m_addr, '0);
            check("rst m_wdata", busIf.m_wdata, '0);
            check("rst acks/bus_err", {busIf.i_ack, busIf.d_ack, busIf.bus_err}, '0);
            check("rst i_rdata", busIf.i_rdata, '0);
            check("rst d_rdata", busIf.d_rdata, '0);
        end else begin
            tmo = TO_EN && mOwner != 0 && !busIf.m_ready && mBusy == TO;
            eI  = (mOwner == 1) && (busIf.m_ready || tmo);
            eD  = (mOwner == 2) && (busIf.m_ready || tmo);
            check("model m_req", busIf.m_req, mOwner != 0);
            if (mOwner != 0) begin
                check("model m_addr", busIf.m_addr, cAddr);
                check("model m_wr/m_wstrb", {busIf.m_wr, busIf.m_wstrb}, {cWr, cWstrb});
            end
            if (mOwner == 2) check("model m_wdata", busIf.m_wdata, cWdata);
            check("model i_ack", busIf.i_ack, eI);
            check("model d_ack", busIf.d_ack, eD);
            check("model i_rdata", busIf.i_rdata, (eI && busIf.m_ready) ? busIf.m_rdata : 32'h0);
            check("model d_rdata", busIf.d_rdata, (eD && busIf.m_ready) ? busIf.m_rdata : 32'h0);
            check("model stall_if", busIf.stall_if, busIf.i_req && !eI);
            check("model stall_mem", busIf.stall_mem, busIf.d_req && !eD);
            check("model bus_err", busIf.bus_err, mBusErr);
        end
    end

    typedef struct {
        bit          isData;
        bit          wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        expWr;
        logic [3:0]  expWstrb;
        logic        expIAck;
        logic        expDAck;
        logic [31:0] expRdata;
    } vecT;

    vecT vecs[6];

    task automatic applyVec(input int idx, input vecT v);
        int  seen = -1;
        bit  done = 1'b0;
        if (v.isData) begin
            busIf.d_req = 1'b1; busIf.d_wr = v.wr; busIf.d_wstrb = v.wstrb;
            busIf.d_addr = v.addr; busIf.d_wdata = v.wdata;
        end else begin
            busIf.i_req = 1'b1; busIf.i_addr = v.addr;
        end
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (cyc > 0) nextCycle();
            if (busIf.m_req && seen < 0) seen = cyc;
            busIf.m_ready = (seen >= 0) && (cyc == seen + v.lat);
            busIf.m_rdata = busIf.m_ready ? v.rdata : $urandom;
            @(negedge clk);
            if (seen >= 0) begin
                check($sformatf("vec%0d m_addr", idx), busIf.m_addr, v.addr);
                check($sformatf("vec%0d m_wr/m_wstrb", idx), {busIf.m_wr, busIf.m_wstrb}, {v.expWr, v.expWstrb});
                if (v.isData) check($sformatf("vec%0d m_wdata", idx), busIf.m_wdata, v.wdata);
            end
            if (busIf.m_ready) begin
                done = 1'b1;
                check($sformatf("vec%0d grant cycle", idx), seen, 1);
                check($sformatf("vec%0d acks", idx), {busIf.i_ack, busIf.d_ack}, {v.expIAck, v.expDAck});
                check($sformatf("vec%0d rdata", idx), v.isData ? busIf.d_rdata : busIf.i_rdata, v.expRdata);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL vec%0d completion: no grant/ack within 20 cycles", idx);
        end
        nextCycle();
        busIf.m_ready = 1'b0; busIf.i_req = 1'b0; busIf.d_req = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d m_req drops", idx), busIf.m_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  nG;
        int  memWait;
        logic iAck, dAck;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'h1111_1111, 0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h1111_1111};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 32'h0000_0080, 32'h0,         32'hDEAD_BEEF, 2, 1'b0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0022, 32'h0000_BEEF, 32'h1234_5678, 5, 1'b1, 4'h3, 1'b0, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 4'hF, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,         1, 1'b1, 4'hF, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'hBFC0_0004, 32'h0,         32'h3C1D_A000, 3, 1'b0, 4'h0, 1'b1, 1'b0, 32'h3C1D_A000};
        vecs[5] = '{1'b1, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h0,         0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0};

        // Reset: stray m_ready must not produce acks or data.
        idleInputs();
        busIf.m_ready = 1'b1; busIf.m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("reset acks", {busIf.i_ack, busIf.d_ack}, 2'b00);
        check("reset m_req", busIf.m_req, 1'b0);
        nextCycle();
        busIf.m_ready = 1'b0;
        nextCycle();
        rst = 1'b0;

        // Single fetch.
        busIf.i_req = 1'b1; busIf.i_addr = 32'hBFC0_0000;
        @(negedge clk);
        check("fetch c0 m_req", busIf.m_req, 1'b0);
        check("fetch c0 stall_if", busIf.stall_if, 1'b1);
        nextCycle();
        @(negedge clk);
        check("fetch c1 m_req", busIf.m_req, 1'b1);
        check("fetch c1 m_addr", busIf.m_addr, 32'hBFC0_0000);
        check("fetch c1 m_wr", busIf.m_wr, 1'b0);
        check("fetch c1 stall_if", busIf.stall_if, 1'b1);
        nextCycle();
        @(negedge clk);
        check("fetch c2 stall_if", busIf.stall_if, 1'b1);
        nextCycle();
        busIf.m_ready = 1'b1; busIf.m_rdata = 32'h2408_0001;
        @(negedge clk);
        check("fetch c3 i_ack", busIf.i_ack, 1'b1);
        check("fetch c3 i_rdata", busIf.i_rdata, 32'h2408_0001);
        check("fetch c3 stall_if", busIf.stall_if, 1'b0);
        nextCycle();
        busIf.m_ready = 1'b0; busIf.i_req = 1'b0;
        @(negedge clk);
        check("fetch c4 m_req", busIf.m_req, 1'b0);

        for (int i = 0; i < 6; i++) begin
            nextCycle();
            applyVec(i, vecs[i]);
        end

        // Simultaneous requests: data first, fetch in the IDLE cycle after d_ack.
        nextCycle();
        busIf.i_req = 1'b1; busIf.i_addr = 32'h0000_1000;
        busIf.d_req = 1'b1; busIf.d_wr = 1'b1; busIf.d_addr = 32'h10;
        busIf.d_wdata = 32'hA5A5_A5A5; busIf.d_wstrb = 4'hF;
        @(negedge clk);
        check("simul c0 m_req", busIf.m_req, 1'b0);
        nextCycle();
        busIf.m_ready = 1'b1; busIf.m_rdata = 32'h7777_7777;
        @(negedge clk);
        check("simul D m_wr/m_wstrb", {busIf.m_wr, busIf.m_wstrb}, 5'h1F);
        check("simul D m_addr", busIf.m_addr, 32'h10);
        check("simul D m_wdata", busIf.m_wdata, 32'hA5A5_A5A5);
        check("simul D acks", {busIf.i_ack, busIf.d_ack}, 2'b01);
        nextCycle();
        busIf.m_ready = 1'b0; busIf.d_req = 1'b0; busIf.d_wr = 1'b0;
        @(negedge clk);
        check("simul idle m_req", busIf.m_req, 1'b0);
        nextCycle();
        busIf.m_ready = 1'b1; busIf.m_rdata = 32'h0C00_0000;
        @(negedge clk);
        check("simul I m_addr", busIf.m_addr, 32'h0000_1000);
        check("simul I m_wr", busIf.m_wr, 1'b0);
        check("simul I i_ack", busIf.i_ack, 1'b1);
        check("simul I i_rdata", busIf.i_rdata, 32'h0C00_0000);
        nextCycle();
        busIf.m_ready = 1'b0; busIf.i_req = 1'b0;

        // Starvation: fetch held, data re-requesting continuously; every (LIMIT+1)th grant goes to fetch.
        resetPulse();
        busIf.i_req = 1'b1; busIf.i_addr = 32'h0000_1000;
        busIf.d_req = 1'b1; busIf.d_wr = 1'b0; busIf.d_addr = 32'h0000_2000; busIf.d_wstrb = '0;
        nG = 0;
        for (int cyc = 0; cyc < 80 && nG < 12; cyc++) begin
            busIf.m_ready = busIf.m_req;
            busIf.m_rdata = $urandom;
            @(negedge clk);
            if (busIf.m_req) begin
                check($sformatf("starve grant %0d addr", nG), busIf.m_addr,
                      ((nG % (LIMIT + 1)) == LIMIT) ? 32'h0000_1000 : 32'h0000_2000);
                nG++;
            end
            nextCycle();
        end
        checks++;
        if (nG < 12) begin
            errors++;
            $display("FAIL starve grant count: actual=%0d required=12", nG);
        end
        busIf.m_ready = 1'b0; busIf.i_req = 1'b0; busIf.d_req = 1'b0;

        // Reset mid-transaction.
        nextCycle();
        busIf.d_req = 1'b1; busIf.d_wr = 1'b0; busIf.d_addr = 32'h30;
        nextCycle();
        @(negedge clk);
        check("rstmid busy m_req", busIf.m_req, 1'b1);
        nextCycle();
        #1;
        rst = 1'b1; busIf.m_ready = 1'b1; busIf.m_rdata = 32'h5555_AAAA;
        #1;
        check("rstmid async m_req", busIf.m_req, 1'b0);
        check("rstmid d_ack", busIf.d_ack, 1'b0);
        nextCycle();
        rst = 1'b0; busIf.m_ready = 1'b0; busIf.d_req = 1'b0;
        busIf.i_req = 1'b1; busIf.i_addr = 32'h40;
        @(negedge clk);
        check("rstmid idle m_req", busIf.m_req, 1'b0);
        nextCycle();
        busIf.m_ready = 1'b1; busIf.m_rdata = 32'h1357_9BDF;
        @(negedge clk);
        check("rstmid I m_addr", busIf.m_addr, 32'h40);
        check("rstmid I i_ack", busIf.i_ack, 1'b1);
        check("rstmid I i_rdata", busIf.i_rdata, 32'h1357_9BDF);
        nextCycle();
        busIf.m_ready = 1'b0; busIf.i_req = 1'b0;

        // Random traffic with stray m_ready pulses; the model checks every cycle.
        memWait = -1; iAck = 1'b0; dAck = 1'b0;
        for (int c = 0; c < 400; c++) begin
            nextCycle();
            if (!busIf.i_req || iAck) begin
                busIf.i_req  = ($urandom_range(0, 2) != 0);
                busIf.i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!busIf.d_req || dAck) begin
                busIf.d_req   = ($urandom_range(0, 2) != 0);
                busIf.d_wr    = 1'($urandom_range(0, 1));
                busIf.d_wstrb = busIf.d_wr ? 4'($urandom_range(1, 15)) : 4'h0;
                busIf.d_addr  = $urandom;
                busIf.d_wdata = $urandom;
            end
            busIf.m_ready = 1'b0;
            busIf.m_rdata = $urandom;
            if (busIf.m_req) begin
                if (memWait < 0) memWait = $urandom_range(0, 3);
                if (memWait == 0) begin
                    busIf.m_ready = 1'b1;
                    memWait = -1;
                end else begin
                    memWait--;
                end
            end else begin
                memWait = -1;
                busIf.m_ready = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            iAck = busIf.i_ack;
            dAck = busIf.d_ack;
        end
        resetPulse();

`ifdef MEM_ARB_TIMEOUT_EN
        busIf.d_req = 1'b1; busIf.d_wr = 1'b0; busIf.d_addr = 32'h50;
        busIf.m_rdata = 32'hDEAD_DEAD;
        for (int c = 1; c <= TO; c++) begin
            nextCycle();
            @(negedge clk);
            check($sformatf("timeout busy c%0d d_ack", c), busIf.d_ack, 1'b0);
        end
        nextCycle();
        @(negedge clk);
        check("timeout d_ack", busIf.d_ack, 1'b1);
        check("timeout d_rdata", busIf.d_rdata, 32'h0);
        nextCycle();
        busIf.d_req = 1'b0;
        @(negedge clk);
        check("timeout bus_err set", busIf.bus_err, 1'b1);
        check("timeout m_req dropped", busIf.m_req, 1'b0);
        nextCycle();
        busIf.m_ready = 1'b1;
        @(negedge clk);
        check("timeout late m_ready acks", {busIf.i_ack, busIf.d_ack}, 2'b00);
        nextCycle();
        busIf.m_ready = 1'b0;
        @(negedge clk);
        check("timeout bus_err sticky", busIf.bus_err, 1'b1);
`endif

        nextCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
